// File: rtl/axi4_stream_shift_arbiter.sv
// ---------------------------------------------------------------------------
// axi4_stream_shift_arbiter
//
// Packet-granular round-robin arbiter that merges PORTS_AMOUNT AXI4-Stream
// sources into one stream feeding the byte-shift stage. When a port is
// granted, its static shift configuration is captured and presented on
// shift_o. That value stays constant for the whole packet, so the shifter
// can latch it on the first beat.
//
// Ports
//   clk_i          clock
//   rst_n_i        synchronous reset, active-low
//   shift_cfg_i    per-port byte shift, captured when the port is granted
//   pkt_i_*        source streams (one lane per port in each packed array)
//   pkt_o_*        merged stream to the byte shifter
//   shift_o        shift value for the current packet
//   grant_o        index of the currently granted port
//   busy_o         high while a packet is being passed
// ---------------------------------------------------------------------------
module axi4_stream_shift_arbiter #(
    parameter int TDATA_WIDTH     = 32,
    parameter int TID_WIDTH       = 1,
    parameter int TDEST_WIDTH     = 1,
    parameter int TUSER_WIDTH     = 1,
    parameter int PORTS_AMOUNT    = 4,
    parameter int TDATA_WIDTH_B   = TDATA_WIDTH / 8,
    parameter int TDATA_WIDTH_B_W = $clog2(TDATA_WIDTH_B),
    parameter int PORTS_W         = $clog2(PORTS_AMOUNT)
) (
    input  logic                                         clk_i,
    input  logic                                         rst_n_i,
    input  logic [PORTS_AMOUNT-1:0][TDATA_WIDTH_B_W-1:0] shift_cfg_i,
    input  logic [PORTS_AMOUNT-1:0]                      pkt_i_tvalid,
    output logic [PORTS_AMOUNT-1:0]                      pkt_i_tready,
    input  logic [PORTS_AMOUNT-1:0][TDATA_WIDTH-1:0]     pkt_i_tdata,
    input  logic [PORTS_AMOUNT-1:0][TDATA_WIDTH_B-1:0]   pkt_i_tkeep,
    input  logic [PORTS_AMOUNT-1:0][TDATA_WIDTH_B-1:0]   pkt_i_tstrb,
    input  logic [PORTS_AMOUNT-1:0]                      pkt_i_tlast,
    input  logic [PORTS_AMOUNT-1:0][TID_WIDTH-1:0]       pkt_i_tid,
    input  logic [PORTS_AMOUNT-1:0][TDEST_WIDTH-1:0]     pkt_i_tdest,
    input  logic [PORTS_AMOUNT-1:0][TUSER_WIDTH-1:0]     pkt_i_tuser,
    output logic                                         pkt_o_tvalid,
    input  logic                                         pkt_o_tready,
    output logic [TDATA_WIDTH-1:0]                       pkt_o_tdata,
    output logic [TDATA_WIDTH_B-1:0]                     pkt_o_tkeep,
    output logic [TDATA_WIDTH_B-1:0]                     pkt_o_tstrb,
    output logic                                         pkt_o_tlast,
    output logic [TID_WIDTH-1:0]                         pkt_o_tid,
    output logic [TDEST_WIDTH-1:0]                       pkt_o_tdest,
    output logic [TUSER_WIDTH-1:0]                       pkt_o_tuser,
    output logic [TDATA_WIDTH_B_W-1:0]                   shift_o,
    output logic [PORTS_W-1:0]                           grant_o,
    output logic                                         busy_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PASS = 1'b1
    } state_t;

    localparam logic [PORTS_W:0] PORTS_AMOUNT_EXT = (PORTS_W + 1)'(PORTS_AMOUNT);

    // Modular add on port indices. Both operands are below PORTS_AMOUNT, so
    // one conditional subtract wraps correctly for non-power-of-2 counts.
    function automatic logic [PORTS_W-1:0] port_add(input logic [PORTS_W-1:0] base,
                                                     input logic [PORTS_W-1:0] off);
        logic [PORTS_W:0] sum_v;
        sum_v = {1'b0, base} + {1'b0, off};
        if (sum_v >= PORTS_AMOUNT_EXT) begin
            sum_v = sum_v - PORTS_AMOUNT_EXT;
        end else begin
            sum_v = sum_v;
        end
        return sum_v[PORTS_W-1:0];
    endfunction

    state_t                     state_r;
    state_t                     state_nxt_s;
    logic [PORTS_W-1:0]         rr_ptr_r;
    logic [PORTS_W-1:0]         grant_r;
    logic [TDATA_WIDTH_B_W-1:0] shift_r;
    logic                       found_s;
    logic [PORTS_W-1:0]         found_idx_s;
    logic                       pass_s;
    logic                       last_hs_s;

    // While reset is asserted, the path is closed. This prevents a beat from
    // being handed over in the same cycle that the state is being discarded.
    assign pass_s    = (state_r == ST_PASS) && rst_n_i;
    assign last_hs_s = pass_s && pkt_i_tvalid[grant_r] && pkt_o_tready && pkt_i_tlast[grant_r];

    assign grant_o = grant_r;
    assign shift_o = shift_r;
    assign busy_o  = (state_r == ST_PASS);

    // Round-robin search: the first valid port at or after rr_ptr wins
    always_comb begin
        logic [PORTS_W-1:0] cand_v;
        found_s     = 1'b0;
        found_idx_s = {PORTS_W{1'b0}};
        cand_v      = {PORTS_W{1'b0}};
        for (int i = 0; i < PORTS_AMOUNT; i++) begin
            cand_v = port_add(rr_ptr_r, PORTS_W'(i));
            if (!found_s && pkt_i_tvalid[cand_v]) begin
                found_s     = 1'b1;
                found_idx_s = cand_v;
            end else begin
                found_s = found_s;
            end
        end
    end

    // State register plus the grant, shift and pointer captured at transitions
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_r  <= ST_IDLE;
            rr_ptr_r <= {PORTS_W{1'b0}};
            grant_r  <= {PORTS_W{1'b0}};
            shift_r  <= {TDATA_WIDTH_B_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == ST_IDLE) && found_s) begin
                grant_r <= found_idx_s;
                shift_r <= shift_cfg_i[found_idx_s];
            end
            if (last_hs_s) begin
                rr_ptr_r <= port_add(grant_r, PORTS_W'(1));
            end
        end
    end

    // Next-state logic: a grant starts PASS; the last beat's handshake ends it
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    state_nxt_s = ST_PASS;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PASS: begin
                if (last_hs_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_PASS;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output mux: the payload always follows the granted port; handshake
    // signals are gated so that nothing moves outside PASS
    always_comb begin
        pkt_o_tdata           = pkt_i_tdata[grant_r];
        pkt_o_tkeep           = pkt_i_tkeep[grant_r];
        pkt_o_tstrb           = pkt_i_tstrb[grant_r];
        pkt_o_tlast           = pkt_i_tlast[grant_r];
        pkt_o_tid             = pkt_i_tid[grant_r];
        pkt_o_tdest           = pkt_i_tdest[grant_r];
        pkt_o_tuser           = pkt_i_tuser[grant_r];
        pkt_o_tvalid          = pass_s && pkt_i_tvalid[grant_r];
        pkt_i_tready          = {PORTS_AMOUNT{1'b0}};
        pkt_i_tready[grant_r] = pass_s && pkt_o_tready;
    end

endmodule

// File: tb/tb_axi4_stream_shift_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for axi4_stream_shift_arbiter. Two instances run in parallel:
// one with four ports and one with three ports, which exercises the
// non-power-of-2 pointer wrap. Sources send AXI-compliant random packets
// with random tvalid gaps. Downstream tready, shift configuration and
// short mid-traffic resets are also randomised. A packet-level reference
// model predicts the grant, the shift value, the handshakes and the
// content of every beat.
// ---------------------------------------------------------------------------
module tb_axi4_stream_shift_arbiter;

    localparam int NCYC = 3000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total    = 0;
    int bad      = 0;
    int done_cnt = 0;

    task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int P  = (g == 0) ? 4 : 3;
        localparam int PW = $clog2(P);

        logic              rst_n;
        logic [P-1:0][1:0] shift_cfg;
        logic [P-1:0]      tvalid, tready, tlast;
        logic [P-1:0][31:0] tdata;
        logic [P-1:0][3:0] tkeep, tstrb;
        logic [P-1:0][0:0] tid, tdest, tuser;
        logic              o_tvalid, o_tready, o_tlast;
        logic [31:0]       o_tdata;
        logic [3:0]        o_tkeep, o_tstrb;
        logic [0:0]        o_tid, o_tdest, o_tuser;
        logic [1:0]        shift;
        logic [PW-1:0]     grant;
        logic              busy;

        axi4_stream_shift_arbiter #(.PORTS_AMOUNT(P)) dut (
            .clk_i(clk), .rst_n_i(rst_n), .shift_cfg_i(shift_cfg),
            .pkt_i_tvalid(tvalid), .pkt_i_tready(tready), .pkt_i_tdata(tdata),
            .pkt_i_tkeep(tkeep), .pkt_i_tstrb(tstrb), .pkt_i_tlast(tlast),
            .pkt_i_tid(tid), .pkt_i_tdest(tdest), .pkt_i_tuser(tuser),
            .pkt_o_tvalid(o_tvalid), .pkt_o_tready(o_tready), .pkt_o_tdata(o_tdata),
            .pkt_o_tkeep(o_tkeep), .pkt_o_tstrb(o_tstrb), .pkt_o_tlast(o_tlast),
            .pkt_o_tid(o_tid), .pkt_o_tdest(o_tdest), .pkt_o_tuser(o_tuser),
            .shift_o(shift), .grant_o(grant), .busy_o(busy)
        );

        initial begin : run
            int  seq[P];
            int  rem[P];
            bit  pend[P];
            bit  exp_rdy[P];
            bit  m_pass;
            int  m_grant, m_shift, m_rr;
            bit  pass, hs, found;
            int  cand;
            string pfx;

            pfx = $sformatf("p%0d_", P);
            for (int k = 0; k < P; k++) begin
                seq[k]  = 0;
                rem[k]  = $urandom_range(1, 4);
                pend[k] = 1'b0;
            end
            m_pass = 1'b0; m_grant = 0; m_shift = 0; m_rr = 0;
            rst_n = 1'b0; o_tready = 1'b0; tvalid = '0; shift_cfg = '0;
            tdata = '0; tkeep = '0; tstrb = '0; tlast = '0; tid = '0; tdest = '0; tuser = '0;
            repeat (3) @(posedge clk);

            for (int cyc = 0; cyc < NCYC; cyc++) begin
                @(negedge clk);
                // New stimulus for this cycle
                rst_n    = !(cyc > 20 && $urandom_range(0, 199) == 0);
                o_tready = rst_n && ($urandom_range(0, 3) != 0);
                for (int k = 0; k < P; k++) begin
                    if ($urandom_range(0, 7) == 0) shift_cfg[k] = 2'($urandom);
                    if (!pend[k]) tvalid[k] = ($urandom_range(0, 9) < 6);
                    tdata[k] = {8'(g), 8'(k), 16'(seq[k])};
                    tkeep[k] = 4'(seq[k] * 5 + k);
                    tstrb[k] = 4'(seq[k] * 3);
                    tlast[k] = (rem[k] == 1);
                    tid[k]   = 1'(seq[k]);
                    tdest[k] = 1'(seq[k] >> 1);
                    tuser[k] = 1'(k + seq[k]);
                end
                #1;
                // Compare against the reference model
                pass = m_pass && rst_n;
                chk_val({pfx, "busy"},  64'(busy),  64'(m_pass));
                chk_val({pfx, "grant"}, 64'(grant), 64'(m_grant));
                chk_val({pfx, "shift"}, 64'(shift), 64'(m_shift));
                for (int k = 0; k < P; k++) begin
                    exp_rdy[k] = pass && (k == m_grant) && o_tready;
                    chk_val($sformatf("%stready%0d", pfx, k), 64'(tready[k]), 64'(exp_rdy[k]));
                end
                if (rst_n) begin
                    chk_val({pfx, "tvalid"}, 64'(o_tvalid), 64'(pass && tvalid[m_grant]));
                    if (pass && tvalid[m_grant]) begin
                        chk_val({pfx, "tdata"}, 64'(o_tdata),
                                64'({8'(g), 8'(m_grant), 16'(seq[m_grant])}));
                        chk_val({pfx, "sideband"},
                                64'({o_tkeep, o_tstrb, o_tlast, o_tid, o_tdest, o_tuser}),
                                64'({4'(seq[m_grant] * 5 + m_grant), 4'(seq[m_grant] * 3),
                                     rem[m_grant] == 1, 1'(seq[m_grant]), 1'(seq[m_grant] >> 1),
                                     1'(m_grant + seq[m_grant])}));
                    end
                end

                @(posedge clk);
                // Advance the model across this edge
                for (int k = 0; k < P; k++) begin
                    hs = tvalid[k] && exp_rdy[k];
                    pend[k] = tvalid[k] && !hs;
                    if (hs) begin
                        seq[k]++;
                        rem[k]--;
                        if (rem[k] == 0) rem[k] = $urandom_range(1, 4);
                    end
                end
                if (!rst_n) begin
                    m_pass = 1'b0; m_grant = 0; m_shift = 0; m_rr = 0;
                end else if (!m_pass) begin
                    found = 1'b0;
                    for (int i = 0; i < P; i++) begin
                        cand = (m_rr + i) % P;
                        if (!found && tvalid[cand]) begin
                            found   = 1'b1;
                            m_pass  = 1'b1;
                            m_grant = cand;
                            m_shift = int'(shift_cfg[cand]);
                        end
                    end
                end else if (tvalid[m_grant] && o_tready && tlast[m_grant]) begin
                    m_pass = 1'b0;
                    m_rr   = (m_grant + 1) % P;
                end
            end
            done_cnt++;
        end
    end

    initial begin
        for (int c = 0; c < NCYC + 200 && done_cnt < 2; c++) @(posedge clk);
        chk_val("run_complete", 64'(done_cnt), 64'(2));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
